// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared widths, register-zero constant and load-queue entry type
package wb_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    // Writes to this register are discarded by the register file.
    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 valid;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - ALU/load/regfile/forwarding signal bundle of the writeback arbiter
interface wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              alu_valid;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;

    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;

    logic [ADDR_W-1:0] fwd_addr_1;
    logic [ADDR_W-1:0] fwd_addr_2;
    logic              fwd_hit_1;
    logic              fwd_hit_2;
    logic [DATA_W-1:0] fwd_data_1;
    logic [DATA_W-1:0] fwd_data_2;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        input  fwd_addr_1, fwd_addr_2,
        output mem_ready, write_addr, write_data,
        output fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
        output count, full, empty
    );

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        output fwd_addr_1, fwd_addr_2,
        input  mem_ready, write_addr, write_data,
        input  fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2,
        input  count, full, empty
    );

endinterface

// File: rtl/wb_arbiter_fwd_match.sv
// rtl/wb_arbiter_fwd_match.sv - youngest-match search over load queue and output stage for one read port
module wb_fwd_match
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic [ADDR_W-1:0]        i_addr,
    input  logic                     i_q_valid [DEPTH],
    input  logic [ADDR_W-1:0]        i_q_addr  [DEPTH],
    input  logic [DATA_W-1:0]        i_q_data  [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] i_head,
    input  logic [ADDR_W-1:0]        i_wb_addr,
    input  logic [DATA_W-1:0]        i_wb_data,
    output logic                     o_hit,
    output logic [DATA_W-1:0]        o_data
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] w_idx;

    // Output stage is checked first so any queue match overrides it; the queue
    // is then walked oldest to youngest so the youngest valid match lands last.
    // Unoccupied slots always have valid cleared, so no occupancy test is needed.
    always_comb begin
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = i_head;
        if (i_addr != ADDR_W'(REG_ZERO)) begin
            if (i_wb_addr == i_addr) begin
                o_hit  = 1'b1;
                o_data = i_wb_data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = i_head + PTR_W'(k);
                if (i_q_valid[w_idx] && (i_q_addr[w_idx] == i_addr)) begin
                    o_hit  = 1'b1;
                    o_data = i_q_data[w_idx];
                end
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - regfile write-port arbiter: ALU priority, in-order load queue, WAW kill, forwarding
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int DATA_W = WB_DATA_W
) (
    input  logic         clk,
    input  logic         reset_n,
    wb_arbiter_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              r_q_valid [DEPTH];
    logic [ADDR_W-1:0] r_q_addr  [DEPTH];
    logic [DATA_W-1:0] r_q_data  [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;

    logic w_full;
    logic w_empty;
    logic w_alu_wr;
    logic w_push;
    logic w_pop;

    assign w_full   = (r_count == CNT_W'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign w_alu_wr = bus.alu_valid && (bus.alu_addr != ADDR_W'(REG_ZERO));
    // Loads to r0 are acknowledged but never take a slot.
    assign w_push   = bus.mem_valid && !w_full && (bus.mem_addr != ADDR_W'(REG_ZERO));
    // The ALU owns the write port whenever it writes, so the queue only drains in its gaps.
    assign w_pop    = !w_alu_wr && !w_empty;

    // Queue storage: WAW kill on ALU match, valid cleared on pop, new load written at tail
    // (a same-edge load to the ALU's register is enqueued already dead).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q_valid[i] <= 1'b0;
                r_q_addr[i]  <= '0;
                r_q_data[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_wr && (r_q_addr[i] == bus.alu_addr)) begin
                    r_q_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_q_valid[r_head] <= 1'b0;
            end
            if (w_push) begin
                r_q_valid[r_tail] <= !(w_alu_wr && (bus.mem_addr == bus.alu_addr));
                r_q_addr[r_tail]  <= bus.mem_addr;
                r_q_data[r_tail]  <= bus.mem_data;
            end
        end
    end

    // Head/tail pointers wrap naturally at DEPTH; count includes killed entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Output stage: ALU result, else queue head (address 0 if killed), else idle;
    // write_data holds whenever no live value is written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (w_alu_wr) begin
            r_wr_addr <= bus.alu_addr;
            r_wr_data <= bus.alu_data;
        end else if (w_pop && r_q_valid[r_head]) begin
            r_wr_addr <= r_q_addr[r_head];
            r_wr_data <= r_q_data[r_head];
        end else begin
            r_wr_addr <= ADDR_W'(REG_ZERO);
        end
    end

    assign bus.write_addr = r_wr_addr;
    assign bus.write_data = r_wr_data;
    assign bus.count      = r_count;
    assign bus.full       = w_full;
    assign bus.empty      = w_empty;
    assign bus.mem_ready  = !w_full;

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_1 (
        .i_addr    (bus.fwd_addr_1),
        .i_q_valid (r_q_valid),
        .i_q_addr  (r_q_addr),
        .i_q_data  (r_q_data),
        .i_head    (r_head),
        .i_wb_addr (r_wr_addr),
        .i_wb_data (r_wr_data),
        .o_hit     (bus.fwd_hit_1),
        .o_data    (bus.fwd_data_1)
    );

    wb_fwd_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_fwd_2 (
        .i_addr    (bus.fwd_addr_2),
        .i_q_valid (r_q_valid),
        .i_q_addr  (r_q_addr),
        .i_q_data  (r_q_data),
        .i_head    (r_head),
        .i_wb_addr (r_wr_addr),
        .i_wb_data (r_wr_data),
        .o_hit     (bus.fwd_hit_2),
        .o_data    (bus.fwd_data_2)
    );

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized bench for wb_arbiter against a queue-level model
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();
    wb_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Model: pending loads in age order plus the value on the write port.
    wb_entry_t   mq[$];
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    function automatic void model_reset();
        mq.delete();
        m_wa = '0;
        m_wd = '0;
    endfunction

    function automatic void model_edge();
        wb_entry_t e;
        bit alu_wr;
        bit acc;
        alu_wr = bus.alu_valid && (bus.alu_addr != 5'd0);
        acc    = bus.mem_valid && (mq.size() < DEPTH);
        if (alu_wr) begin
            m_wa = bus.alu_addr;
            m_wd = bus.alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.valid) begin
                m_wa = e.addr;
                m_wd = e.data;
            end else begin
                m_wa = '0;
            end
        end else begin
            m_wa = '0;
        end
        if (alu_wr) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (mq[i].addr == bus.alu_addr) begin
                    e = mq[i];
                    e.valid = 1'b0;
                    mq[i] = e;
                end
            end
        end
        if (acc && (bus.mem_addr != 5'd0)) begin
            e.valid = !(alu_wr && (bus.mem_addr == bus.alu_addr));
            e.addr  = bus.mem_addr;
            e.data  = bus.mem_data;
            mq.push_back(e);
        end
    endfunction

    function automatic void model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
        if (a == 5'd0) return;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].valid && (mq[i].addr == a)) begin
                hit = 1'b1;
                d   = mq[i].data;
                return;
            end
        end
        if (m_wa == a) begin
            hit = 1'b1;
            d   = m_wd;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid  = 1'b0;
        bus.alu_addr   = '0;
        bus.alu_data   = '0;
        bus.mem_valid  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_data   = '0;
    endtask

    task automatic test_reset();
        checks++; if (bus.write_addr !== 5'd0 || bus.write_data !== 32'd0) begin errors++;
            $display("FAIL reset_write got %0d/%h exp 0/0", bus.write_addr, bus.write_data); end
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.mem_ready !== 1'b1) begin errors++;
            $display("FAIL reset_status got count=%0d empty=%b full=%b ready=%b exp 0 1 0 1", bus.count, bus.empty, bus.full, bus.mem_ready); end
    endtask

    task automatic test_alu();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd3; bus.alu_data = 32'h1111;
        step();
        idle_inputs();
        bus.fwd_addr_1 = 5'd3;
        #1;
        checks++; if (bus.write_addr !== 5'd3 || bus.write_data !== 32'h1111) begin errors++;
            $display("FAIL alu_write got %0d/%h exp 3/1111", bus.write_addr, bus.write_data); end
        checks++; if (bus.fwd_hit_1 !== 1'b1 || bus.fwd_data_1 !== 32'h1111) begin errors++;
            $display("FAIL alu_fwd got %b/%h exp 1/1111", bus.fwd_hit_1, bus.fwd_data_1); end
        step();
        checks++; if (bus.write_addr !== 5'd0 || bus.write_data !== 32'h1111) begin errors++;
            $display("FAIL alu_idle got %0d/%h exp 0/1111", bus.write_addr, bus.write_data); end
    endtask

    task automatic test_load();
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd5; bus.mem_data = 32'hAAAA;
        step();
        idle_inputs();
        bus.fwd_addr_2 = 5'd5;
        #1;
        checks++; if (bus.count !== 3'd1 || bus.write_addr !== 5'd0) begin errors++;
            $display("FAIL load_queued got count=%0d wa=%0d exp 1 0", bus.count, bus.write_addr); end
        checks++; if (bus.fwd_hit_2 !== 1'b1 || bus.fwd_data_2 !== 32'hAAAA) begin errors++;
            $display("FAIL load_fwd got %b/%h exp 1/aaaa", bus.fwd_hit_2, bus.fwd_data_2); end
        step();
        checks++; if (bus.write_addr !== 5'd5 || bus.write_data !== 32'hAAAA || bus.empty !== 1'b1) begin errors++;
            $display("FAIL load_write got %0d/%h empty=%b exp 5/aaaa 1", bus.write_addr, bus.write_data, bus.empty); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 5'(10 + i); bus.alu_data = 32'(i);
            bus.mem_valid = 1'b1; bus.mem_addr = 5'(1 + i);   bus.mem_data = 32'h100 * (i + 1);
            step();
        end
        idle_inputs();
        checks++; if (bus.full !== 1'b1 || bus.mem_ready !== 1'b0 || bus.count !== 3'd4) begin errors++;
            $display("FAIL fill_full got full=%b ready=%b count=%0d exp 1 0 4", bus.full, bus.mem_ready, bus.count); end
        checks++; if (bus.write_addr !== 5'd13) begin errors++;
            $display("FAIL fill_alu got %0d exp 13", bus.write_addr); end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.write_addr !== 5'(i + 1) || bus.write_data !== 32'h100 * (i + 1)) begin errors++;
                $display("FAIL drain_%0d got %0d/%h exp %0d/%h", i, bus.write_addr, bus.write_data, i + 1, 32'h100 * (i + 1)); end
            if (i == 0) begin
                checks++; if (bus.mem_ready !== 1'b1 || bus.count !== 3'd3) begin errors++;
                    $display("FAIL drain_ready got ready=%b count=%0d exp 1 3", bus.mem_ready, bus.count); end
            end
        end
        checks++; if (bus.empty !== 1'b1) begin errors++;
            $display("FAIL drain_empty got %b exp 1", bus.empty); end
    endtask

    task automatic test_waw();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd20; bus.alu_data = 32'h20;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd7;  bus.mem_data = 32'h7;
        step();
        bus.mem_data = 32'h77;
        step();
        bus.mem_valid = 1'b0;
        bus.alu_addr = 5'd7; bus.alu_data = 32'h700;
        bus.fwd_addr_1 = 5'd7;
        #1;
        checks++; if (bus.fwd_hit_1 !== 1'b1 || bus.fwd_data_1 !== 32'h77 || bus.count !== 3'd2) begin errors++;
            $display("FAIL waw_youngest got %b/%h count=%0d exp 1/77 2", bus.fwd_hit_1, bus.fwd_data_1, bus.count); end
        step();
        idle_inputs();
        #1;
        checks++; if (bus.write_addr !== 5'd7 || bus.write_data !== 32'h700 || bus.fwd_data_1 !== 32'h700 || bus.fwd_hit_1 !== 1'b1) begin errors++;
            $display("FAIL waw_alu got %0d/%h fwd=%b/%h exp 7/700 1/700", bus.write_addr, bus.write_data, bus.fwd_hit_1, bus.fwd_data_1); end
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (bus.write_addr !== 5'd0 || bus.count !== 3'(1 - i)) begin errors++;
                $display("FAIL waw_killpop_%0d got wa=%0d count=%0d exp 0 %0d", i, bus.write_addr, bus.count, 1 - i); end
        end
    endtask

    task automatic test_same_edge();
        bus.alu_valid = 1'b1; bus.alu_addr = 5'd9; bus.alu_data = 32'h9;
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd9; bus.mem_data = 32'h90;
        step();
        idle_inputs();
        bus.fwd_addr_2 = 5'd9;
        #1;
        checks++; if (bus.write_addr !== 5'd9 || bus.count !== 3'd1 || bus.fwd_data_2 !== 32'h9) begin errors++;
            $display("FAIL same_edge got wa=%0d count=%0d fwd=%h exp 9 1 9", bus.write_addr, bus.count, bus.fwd_data_2); end
        step();
        checks++; if (bus.write_addr !== 5'd0 || bus.write_data !== 32'h9 || bus.empty !== 1'b1) begin errors++;
            $display("FAIL same_edge_pop got %0d/%h empty=%b exp 0/9 1", bus.write_addr, bus.write_data, bus.empty); end
        bus.mem_valid = 1'b1; bus.mem_addr = 5'd0; bus.mem_data = 32'hDEAD;
        step();
        idle_inputs();
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1) begin errors++;
            $display("FAIL r0_load got count=%0d empty=%b exp 0 1", bus.count, bus.empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1; bus.alu_addr = 5'd21; bus.alu_data = 32'h21;
            bus.mem_valid = 1'b1; bus.mem_addr = 5'(1 + i); bus.mem_data = 32'h5000 + i;
            step();
        end
        idle_inputs();
        checks++; if (bus.count !== 3'd3) begin errors++;
            $display("FAIL rst_pre got count=%0d exp 3", bus.count); end
        #1;
        reset_n = 1'b0;
        #1;
        model_reset();
        bus.fwd_addr_1 = 5'd1;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.empty !== 1'b1 || bus.mem_ready !== 1'b1 || bus.write_addr !== 5'd0 || bus.write_data !== 32'd0 || bus.fwd_hit_1 !== 1'b0) begin errors++;
            $display("FAIL rst_async got count=%0d empty=%b ready=%b wa=%0d wd=%h hit=%b", bus.count, bus.empty, bus.mem_ready, bus.write_addr, bus.write_data, bus.fwd_hit_1); end
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (bus.write_addr !== 5'd0) begin errors++;
                $display("FAIL rst_nowrite_%0d got %0d exp 0", i, bus.write_addr); end
        end
    endtask

    task automatic test_random();
        logic        h1, h2;
        logic [31:0] d1, d2;
        for (int n = 0; n < 400; n++) begin
            bus.alu_valid  = ($urandom_range(0, 99) < 40);
            bus.alu_addr   = 5'($urandom_range(0, 7));
            bus.alu_data   = $urandom;
            bus.mem_valid  = ($urandom_range(0, 99) < 60);
            bus.mem_addr   = 5'($urandom_range(0, 7));
            bus.mem_data   = $urandom;
            bus.fwd_addr_1 = 5'($urandom_range(0, 7));
            bus.fwd_addr_2 = 5'($urandom_range(0, 7));
            #1;
            model_fwd(bus.fwd_addr_1, h1, d1);
            model_fwd(bus.fwd_addr_2, h2, d2);
            checks++; if (bus.fwd_hit_1 !== h1 || bus.fwd_data_1 !== d1 || bus.fwd_hit_2 !== h2 || bus.fwd_data_2 !== d2) begin errors++;
                $display("FAIL rnd_fwd n=%0d got %b/%h %b/%h exp %b/%h %b/%h", n, bus.fwd_hit_1, bus.fwd_data_1, bus.fwd_hit_2, bus.fwd_data_2, h1, d1, h2, d2); end
            step();
            checks++; if (bus.write_addr !== m_wa || bus.write_data !== m_wd) begin errors++;
                $display("FAIL rnd_write n=%0d got %0d/%h exp %0d/%h", n, bus.write_addr, bus.write_data, m_wa, m_wd); end
            checks++; if (bus.count !== 3'(mq.size()) || bus.full !== (mq.size() == DEPTH) || bus.empty !== (mq.size() == 0) || bus.mem_ready !== (mq.size() != DEPTH)) begin errors++;
                $display("FAIL rnd_status n=%0d got count=%0d full=%b empty=%b ready=%b exp count=%0d", n, bus.count, bus.full, bus.empty, bus.mem_ready, mq.size()); end
        end
        idle_inputs();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        bus.fwd_addr_1 = '0;
        bus.fwd_addr_2 = '0;
        model_reset();
        #12;
        test_reset();
        reset_n = 1'b1;
        step();
        test_alu();
        test_load();
        test_fill_drain();
        test_waw();
        test_same_edge();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter driving the single write port of the processor register file. It merges same-cycle ALU results with variable-latency load returns, buffering loads in a small in-order queue. It drops WAW-stale loads and forwards not-yet-committed values to the two decode read ports. It sits between the execute/memory stages and the register file's `write_addr`/`write_data` inputs.

## Interface
- `DEPTH`, 4: load-queue entries (power of two, ≥2)
- `ADDR_W`, 5: register address width
- `DATA_W`, 32: register data width

- `clk` in 1: clock, rising edge
- `reset_n` in 1: asynchronous, active-low reset; one clock domain
- `alu_valid` in 1: ALU result present this cycle (always accepted)
- `alu_addr` in ADDR_W: ALU destination register
- `alu_data` in DATA_W: ALU result
- `mem_valid` in 1: load return offered
- `mem_ready` out 1: queue can accept; equals `!full`
- `mem_addr` in ADDR_W: load destination register
- `mem_data` in DATA_W: load data
- `write_addr` out ADDR_W: to regfile; 0 = no write
- `write_data` out DATA_W: to regfile
- `fwd_addr_1`, `fwd_addr_2` in ADDR_W: decode read addresses
- `fwd_hit_1`, `fwd_hit_2` out 1: pending value exists for that address
- `fwd_data_1`, `fwd_data_2` out DATA_W: pending value, valid when hit
- `count` out clog2(DEPTH)+1: occupied queue entries, killed entries included
- `full`, `empty` out 1: queue status

## Operation
- Load accepted on edge when `mem_valid && mem_ready`.
- Load with `mem_addr == 0` is accepted and discarded; it is not enqueued.
- Queue entries hold {valid, addr, data}, FIFO order, head/tail pointers wrap modulo DEPTH.
- Output stage: registers `write_addr`/`write_data`. Each edge, the stage loads exactly one of the following, by priority:
  1. An ALU result when `alu_valid && alu_addr != 0`. The queue does not pop.
  2. The queue head when the queue is non-empty. Head pops. If the head is killed, load `write_addr = 0`.
  3. `write_addr = 0`, with `write_data` holding its previous value.
- WAW kill: an accepted ALU write to X clears `valid` of every queue entry with addr X. This includes a load to X enqueued on the same edge. The ALU result is defined as younger.
- Forwarding is combinational, per port.
  - Address 0 gives no hit.
  - Otherwise the youngest valid queue entry matching the address wins.
  - Failing that, the output stage wins if `write_addr` matches.
  - Otherwise no hit and `fwd_data = 0`.
- Simultaneous enqueue and pop when non-full: `count` unchanged.
- Full with no ALU write: pop frees a slot; `mem_ready` rises the next cycle, not combinationally.

## Timing
- Reset values (asynchronous): `write_addr = 0`, `write_data = 0`, queue empty, `count = 0`, `empty = 1`, `full = 0`, `mem_ready = 1`, all valid bits cleared.
- Reset mid-operation discards all queued loads without writing them.
- ALU latency: accepted at edge N, so `write_addr`/`write_data` show it after edge N; the regfile commits it at edge N+1.
- Load latency with an empty queue and no ALU traffic: enqueue at edge N, on the write port after edge N+1.
- Continuous ALU traffic starves the queue. The upstream block guarantees gaps; no starvation counter is required.
- A killed head consumes one cycle with `write_addr = 0`.

## Structure
- Shared package `wb_pkg` holds:
  - `ADDR_W` and `DATA_W` defaults
  - the queue entry struct/typedef {valid, addr, data}
  - the `REG_ZERO` constant
- One sub-module: `wb_fwd_match`. It is a combinational youngest-match search over queue entries plus the output stage, instantiated once per read port.

## Test plan
- Reset, then ALU write r3=0x1111 → after the next edge `write_addr=3`, `write_data=0x1111`; `fwd_hit_1` asserted for `fwd_addr_1=3` with data 0x1111.
- Load r5=0xAAAA with queue empty and no ALU traffic → `write_addr=5` two edges after acceptance; `fwd_hit` for r5 is asserted while queued.
- Four loads r1..r4 with `alu_valid` held for 4 cycles → `full=1`, `mem_ready=0`, `count=4`. ALU drops, queue drains r1,r2,r3,r4 in order, `empty=1`.
- Queue loads r7=0x7 and r7=0x77, then forward r7 → data 0x77. Then ALU r7=0x700 → both entries killed, two idle pops with `write_addr=0`, and the final regfile r7 is 0x700.
- Same-edge ALU r9=0x9 and load r9=0x90 → load killed; r9 ends 0x9. A load to r0 is discarded, and `count` is unchanged.
- Assert `reset_n` low with 3 entries queued → all outputs at reset values immediately (asynchronous); no writes are emitted after release.
